// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - load-control, byte-stream and instruction-memory bus bundle for imem_loader
//
// Signals:
//   load_start, load_words       load request and word count (host -> loader)
//   byte_valid, byte_data        program byte stream, little-endian per word (source -> loader)
//   byte_ready                   loader accepts the byte this cycle (loader -> source)
//   imem_write, imem_addr,       instruction memory write port (loader -> memory)
//   imem_data
//   busy, done, error, core_hold status to host and fetch stage (loader -> host)
// Modports:
//   master  the loader side
//   slave   the host / byte source / memory side
interface imem_loader_if;
    logic        load_start;
    logic [15:0] load_words;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_write;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        busy;
    logic        done;
    logic        error;
    logic        core_hold;

    modport master (
        input  load_start, load_words, byte_valid, byte_data,
        output byte_ready, imem_write, imem_addr, imem_data,
        output busy, done, error, core_hold
    );

    modport slave (
        output load_start, load_words, byte_valid, byte_data,
        input  byte_ready, imem_write, imem_addr, imem_data,
        input  busy, done, error, core_hold
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams program bytes into instruction memory as 32-bit words
//
// Ports:
//   clock   system clock, all state updates on the rising edge
//   reset   synchronous, active-high; abandons any load in progress
//   bus     imem_loader_if.master: load request, byte stream, imem write port, status
// Parameters:
//   BASE_ADDR  byte address of the first loaded word
//   MAX_WORDS  largest accepted load_words value
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h01000000,
    parameter int          MAX_WORDS = 16384
) (
    input  logic          clock,
    input  logic          reset,
    imem_loader_if.master bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      state_q;
    state_t      state_d;

    logic [15:0] words_q;
    logic [15:0] index_q;
    logic [15:0] index_inc;
    logic [1:0]  byte_cnt_q;
    logic [31:0] word_q;
    logic [31:0] word_next;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        error_q;
    logic        loaded_q;

    logic        start_ok;
    logic        start_bad;
    logic        byte_ready_c;
    logic        imem_write_c;
    logic        busy_c;
    logic        done_c;

    assign start_ok  = bus.load_start && (bus.load_words != 16'd0)
                       && ({1'b0, bus.load_words} <= MAX_W);
    assign start_bad = bus.load_start && !start_ok;
    assign index_inc = index_q + 16'd1;

    // Bytes enter at the top and shift down, so after four transfers
    // byte 0 sits in [7:0] and byte 3 in [31:24].
    assign word_next = {bus.byte_data, word_q[31:8]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_ready_c = 1'b0;
        imem_write_c = 1'b0;
        busy_c       = 1'b1;
        done_c       = 1'b0;
        case (state_q)
            IDLE: begin
                busy_c = 1'b0;
                if (start_ok) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                byte_ready_c = 1'b1;
                if (bus.byte_valid && (byte_cnt_q == 2'd3)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                imem_write_c = 1'b1;
                state_d      = (index_inc == words_q) ? DONE : COLLECT;
            end
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            words_q    <= 16'd0;
            index_q    <= 16'd0;
            byte_cnt_q <= 2'd0;
            word_q     <= 32'd0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            error_q    <= 1'b0;
            loaded_q   <= 1'b0;
        end else begin
            error_q <= (state_q == IDLE) && start_bad;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        words_q    <= bus.load_words;
                        index_q    <= 16'd0;
                        byte_cnt_q <= 2'd0;
                        word_q     <= 32'd0;
                    end
                end
                COLLECT: begin
                    if (bus.byte_valid) begin
                        word_q     <= word_next;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        // Latch the write port on the final byte so it is
                        // stable throughout WRITE and holds afterwards.
                        if (byte_cnt_q == 2'd3) begin
                            addr_q <= BASE_ADDR + {14'd0, index_q, 2'b00};
                            data_q <= word_next;
                        end
                    end
                end
                WRITE: begin
                    index_q <= index_inc;
                end
                DONE: begin
                    loaded_q <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_c;
    assign bus.imem_write = imem_write_c;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_data  = data_q;
    assign bus.busy       = busy_c;
    assign bus.done       = done_c;
    assign bus.error      = error_q;
    // Fetch stays held until a program has been loaded, and during any reload.
    assign bus.core_hold  = busy_c || !loaded_q;

endmodule
